// File: rtl/id_stage_p.sv
// id_stage_p: MIPS instruction-decode stage with register file, branch operand
// forwarding/compare, load-use stall and ID/EX register. Optional macro: ID_BYPASS_EN.
module id_stage_p #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       inst_in,
  input  logic              if_valid,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic              sign_ext,
  input  logic              ex_mem_read,
  input  logic [AW-1:0]     ex_rt,
  input  logic              flush,
  output logic              stall,
  output logic              cmp_eq,
  output logic [DATA_W-1:0] branch_target,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_pc,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic [AW-1:0]     idex_rs,
  output logic [AW-1:0]     idex_rt,
  output logic [AW-1:0]     idex_rd
);

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [15:0] field,
                                                       input logic        sx);
    logic signed [15:0] sfield;
    sfield = field;
    if (sx) return DATA_W'(sfield);
    else    return DATA_W'(field);
  endfunction

  function automatic logic [DATA_W-1:0] sel_operand(input logic [1:0]        sel,
                                                    input logic [DATA_W-1:0] rf,
                                                    input logic [DATA_W-1:0] ex,
                                                    input logic [DATA_W-1:0] mem,
                                                    input logic [DATA_W-1:0] wb);
    case (sel)
      2'd0:    return rf;
      2'd1:    return ex;
      2'd2:    return mem;
      default: return wb;
    endcase
  endfunction

  logic [AW-1:0]            rs, rt, rd;
  logic [DATA_W-1:0]        regs_q [NREG];
  logic [DATA_W-1:0]        rs_rdata, rt_rdata;
  logic [DATA_W-1:0]        opnd_a, opnd_b;
  logic signed [DATA_W-1:0] imm_ext;
  logic                     hazard;
  logic                     unused_inst;

  assign rs = inst_in[21 +: AW];
  assign rt = inst_in[16 +: AW];
  assign rd = inst_in[11 +: AW];
  // Opcode/funct and the high register-field bits are decoded elsewhere.
  assign unused_inst = ^inst_in;

  // Register file: register 0 is never written and always reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_rdata = (rs == '0) ? '0 : regs_q[rs];
    rt_rdata = (rt == '0) ? '0 : regs_q[rt];
`ifdef ID_BYPASS_EN
    // Write-before-read: a same-cycle write-back is visible to both read ports.
    if (wb_we && (wb_addr != '0) && (wb_addr == rs)) rs_rdata = wb_data;
    if (wb_we && (wb_addr != '0) && (wb_addr == rt)) rt_rdata = wb_data;
`endif
  end

  assign opnd_a = sel_operand(fwd_a_sel, rs_rdata, ex_fwd_data, mem_fwd_data, wb_data);
  assign opnd_b = sel_operand(fwd_b_sel, rt_rdata, ex_fwd_data, mem_fwd_data, wb_data);
  assign cmp_eq = (opnd_a == opnd_b);

  assign imm_ext       = ext_imm(inst_in[15:0], sign_ext);
  assign branch_target = pc_in + {imm_ext[DATA_W-3:0], 2'b00};

  // Flush squashes the ID instruction, so it also cancels any load-use stall.
  assign hazard = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
  assign stall  = if_valid && hazard && !flush;

  // ---- ID/EX pipeline register ----
  logic              idex_valid_q,   idex_valid_d;
  logic [DATA_W-1:0] idex_pc_q,      idex_pc_d;
  logic [DATA_W-1:0] idex_rs_data_q, idex_rs_data_d;
  logic [DATA_W-1:0] idex_rt_data_q, idex_rt_data_d;
  logic [DATA_W-1:0] idex_imm_q,     idex_imm_d;
  logic [AW-1:0]     idex_rs_q,      idex_rs_d;
  logic [AW-1:0]     idex_rt_q,      idex_rt_d;
  logic [AW-1:0]     idex_rd_q,      idex_rd_d;

  always_comb begin
    idex_valid_d   = 1'b0;
    idex_pc_d      = '0;
    idex_rs_data_d = '0;
    idex_rt_data_d = '0;
    idex_imm_d     = '0;
    idex_rs_d      = '0;
    idex_rt_d      = '0;
    idex_rd_d      = '0;
    if (!(flush || stall)) begin
      idex_valid_d   = if_valid;
      idex_pc_d      = pc_in;
      idex_rs_data_d = rs_rdata;
      idex_rt_data_d = rt_rdata;
      idex_imm_d     = imm_ext;
      idex_rs_d      = rs;
      idex_rt_d      = rt;
      idex_rd_d      = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q   <= 1'b0;
      idex_pc_q      <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
    end else begin
      idex_valid_q   <= idex_valid_d;
      idex_pc_q      <= idex_pc_d;
      idex_rs_data_q <= idex_rs_data_d;
      idex_rt_data_q <= idex_rt_data_d;
      idex_imm_q     <= idex_imm_d;
      idex_rs_q      <= idex_rs_d;
      idex_rt_q      <= idex_rt_d;
      idex_rd_q      <= idex_rd_d;
    end
  end

  assign idex_valid   = idex_valid_q;
  assign idex_pc      = idex_pc_q;
  assign idex_rs_data = idex_rs_data_q;
  assign idex_rt_data = idex_rt_data_q;
  assign idex_imm     = idex_imm_q;
  assign idex_rs      = idex_rs_q;
  assign idex_rt      = idex_rt_q;
  assign idex_rd      = idex_rd_q;

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: directed scenarios plus randomized traffic against a
// behavioural model; a second instance covers DATA_W=16, NREG=8.
module tb_id_stage_p;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] pc_in, inst_in, wb_data, ex_fwd_data, mem_fwd_data;
  logic        if_valid, wb_we, sign_ext, ex_mem_read, flush;
  logic [4:0]  wb_addr, ex_rt;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, cmp_eq, idex_valid;
  logic [31:0] branch_target, idex_pc, idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;

  id_stage_p #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in), .if_valid(if_valid),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_data(mem_fwd_data), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .sign_ext(sign_ext), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .stall(stall), .cmp_eq(cmp_eq), .branch_target(branch_target),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs_data(idex_rs_data),
    .idex_rt_data(idex_rt_data), .idex_imm(idex_imm), .idex_rs(idex_rs),
    .idex_rt(idex_rt), .idex_rd(idex_rd));

  // Small configuration instance
  logic [15:0] s_pc, s_wb_data, s_ex, s_mem, s_bt, s_idex_pc, s_idex_rs_data, s_idex_rt_data, s_idex_imm;
  logic [31:0] s_inst;
  logic        s_if_valid, s_wb_we, s_sx, s_exr, s_flush, s_stall, s_cmp_eq, s_idex_valid;
  logic [2:0]  s_wb_addr, s_ex_rt, s_idex_rs, s_idex_rt, s_idex_rd;
  logic [1:0]  s_fa, s_fb;

  id_stage_p #(.DATA_W(16), .NREG(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .pc_in(s_pc), .inst_in(s_inst), .if_valid(s_if_valid),
    .wb_we(s_wb_we), .wb_addr(s_wb_addr), .wb_data(s_wb_data), .ex_fwd_data(s_ex),
    .mem_fwd_data(s_mem), .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .sign_ext(s_sx),
    .ex_mem_read(s_exr), .ex_rt(s_ex_rt), .flush(s_flush), .stall(s_stall),
    .cmp_eq(s_cmp_eq), .branch_target(s_bt), .idex_valid(s_idex_valid),
    .idex_pc(s_idex_pc), .idex_rs_data(s_idex_rs_data), .idex_rt_data(s_idex_rt_data),
    .idex_imm(s_idex_imm), .idex_rs(s_idex_rs), .idex_rt(s_idex_rt), .idex_rd(s_idex_rd));

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural register contents as the spec describes them.
  logic [31:0] mregs [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      mregs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
    if (wb_we && wb_addr == r) return wb_data;
`endif
    return mregs[r];
  endfunction

  function automatic logic [31:0] m_imm();
    int v;
    v = int'(inst_in[15:0]);
    if (sign_ext && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_opnd(input logic [1:0] sel, input logic [4:0] r);
    case (sel)
      2'd0:    return mread(r);
      2'd1:    return ex_fwd_data;
      2'd2:    return mem_fwd_data;
      default: return wb_data;
    endcase
  endfunction

  function automatic logic m_stall();
    return if_valid && ex_mem_read && ex_rt != 5'd0 &&
           (ex_rt == inst_in[25:21] || ex_rt == inst_in[20:16]) && !flush;
  endfunction

  function automatic idex_t m_idex();
    idex_t e;
    e = '0;
    if (flush || m_stall()) return e;
    e.valid = if_valid;
    e.pc    = pc_in;
    e.rsd   = mread(inst_in[25:21]);
    e.rtd   = mread(inst_in[20:16]);
    e.imm   = m_imm();
    e.rs    = inst_in[25:21];
    e.rt    = inst_in[20:16];
    e.rd    = inst_in[15:11];
    return e;
  endfunction

  function automatic idex_t obs_idex();
    return '{idex_valid, idex_pc, idex_rs_data, idex_rt_data, idex_imm,
             idex_rs, idex_rt, idex_rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_in = 0; inst_in = 0; if_valid = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_fwd_data = 0; mem_fwd_data = 0; fwd_a_sel = 0; fwd_b_sel = 0; sign_ext = 0;
    ex_mem_read = 0; ex_rt = 0; flush = 0;
  endtask

  task automatic test_reset();
    idx_loop: for (int k = 0; k < 3; k++) begin
      pc_in = $urandom; inst_in = $urandom; if_valid = 1; wb_we = 1;
      wb_addr = 5'($urandom); wb_data = $urandom;
      fwd_a_sel = 1; fwd_b_sel = 2; ex_fwd_data = 32'd5; mem_fwd_data = 32'd5;
      ex_mem_read = 1; ex_rt = inst_in[25:21] | 5'd1; inst_in[25:21] = ex_rt; flush = 0;
      #1;
      n_cmp++;
      if (obs_idex() !== idex_t'('0)) begin
        n_fail++; $display("FAIL reset_idex: got %h want 0", obs_idex());
      end
      n_cmp++;
      if (cmp_eq !== 1'b1) begin n_fail++; $display("FAIL reset_cmp_eq: got %b want 1", cmp_eq); end
      n_cmp++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b want 1", stall); end
      tick();
    end
    idle();
    rst_n = 1'b1;
    tick();
    // After reset every register, including the one written during reset, reads 0.
    inst_in[25:21] = 5'($urandom_range(1, 31)); if_valid = 1;
    tick();
    n_cmp++;
    if (idex_rs_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: got %h want 0", idex_rs_data);
    end
    idle();
  endtask

  task automatic test_write_read();
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_we = 0; inst_in = 0; inst_in[25:21] = 5'd5; if_valid = 1; pc_in = 32'h40;
    tick();
    n_cmp++;
    if (idex_rs_data !== 32'hDEADBEEF || idex_valid !== 1'b1 || idex_pc !== 32'h40) begin
      n_fail++; $display("FAIL write_read: got %h/%b/%h want deadbeef/1/40", idex_rs_data, idex_valid, idex_pc);
    end
    idle();
  endtask

  task automatic test_r0();
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 0; inst_in = 0; if_valid = 1; fwd_a_sel = 0; fwd_b_sel = 1; ex_fwd_data = 0;
    #1;
    n_cmp++;
    if (cmp_eq !== 1'b1) begin n_fail++; $display("FAIL r0_cmp: got %b want 1", cmp_eq); end
    tick();
    n_cmp++;
    if (idex_rs_data !== 32'd0) begin n_fail++; $display("FAIL r0_read: got %h want 0", idex_rs_data); end
    idle();
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
`ifdef ID_BYPASS_EN
    exp = 32'hA5A5A5A5;
`else
    exp = 32'h11111111;
`endif
    wb_we = 1; wb_addr = 5'd7; wb_data = 32'h11111111;
    tick();
    wb_data = 32'hA5A5A5A5; inst_in = 0; inst_in[20:16] = 5'd7; if_valid = 1;
    fwd_a_sel = 1; ex_fwd_data = exp; fwd_b_sel = 0;
    #1;
    n_cmp++;
    if (cmp_eq !== 1'b1) begin n_fail++; $display("FAIL bypass_cmp: got %b want 1", cmp_eq); end
    tick();
    n_cmp++;
    if (idex_rt_data !== exp) begin n_fail++; $display("FAIL bypass_rt: got %h want %h", idex_rt_data, exp); end
    idle();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_rt = 5'd9; inst_in = 0; inst_in[25:21] = 5'd9; if_valid = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
    tick();
    n_cmp++;
    if (obs_idex() !== idex_t'('0)) begin n_fail++; $display("FAIL lu_bubble: got %h want 0", obs_idex()); end
    ex_mem_read = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", stall); end
    tick();
    n_cmp++;
    if (idex_valid !== 1'b1 || idex_rs !== 5'd9) begin
      n_fail++; $display("FAIL lu_load: got %b/%0d want 1/9", idex_valid, idex_rs);
    end
    // Reset in the middle of a stall; first edge after release loads normally.
    ex_mem_read = 1;
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if (obs_idex() !== idex_t'('0)) begin n_fail++; $display("FAIL lu_reset: got %h want 0", obs_idex()); end
    ex_mem_read = 0;
    rst_n = 1;
    tick();
    n_cmp++;
    if (idex_valid !== 1'b1 || idex_rs !== 5'd9) begin
      n_fail++; $display("FAIL lu_after_reset: got %b/%0d want 1/9", idex_valid, idex_rs);
    end
    idle();
  endtask

  task automatic test_branch();
    fwd_a_sel = 1; ex_fwd_data = 32'd42; fwd_b_sel = 2; mem_fwd_data = 32'd42;
    pc_in = 32'h100; inst_in = 32'h0000FFFF; sign_ext = 1; if_valid = 1;
    #1;
    n_cmp++;
    if (cmp_eq !== 1'b1) begin n_fail++; $display("FAIL br_eq: got %b want 1", cmp_eq); end
    n_cmp++;
    if (branch_target !== 32'hFC) begin n_fail++; $display("FAIL br_target_sx: got %h want fc", branch_target); end
    mem_fwd_data = 32'd43;
    #1;
    n_cmp++;
    if (cmp_eq !== 1'b0) begin n_fail++; $display("FAIL br_ne: got %b want 0", cmp_eq); end
    sign_ext = 0;
    #1;
    n_cmp++;
    if (branch_target !== 32'h400FC) begin n_fail++; $display("FAIL br_target_zx: got %h want 400fc", branch_target); end
    tick();
    n_cmp++;
    if (idex_imm !== 32'h0000FFFF) begin n_fail++; $display("FAIL br_imm_zx: got %h want 0000ffff", idex_imm); end
    idle();
  endtask

  task automatic test_flush_stall();
    ex_mem_read = 1; ex_rt = 5'd3; inst_in = 0; inst_in[20:16] = 5'd3; if_valid = 1; flush = 1;
    pc_in = 32'h200;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL fs_stall: got %b want 0", stall); end
    tick();
    n_cmp++;
    if (obs_idex() !== idex_t'('0)) begin n_fail++; $display("FAIL fs_bubble: got %h want 0", obs_idex()); end
    idle();
  endtask

  task automatic test_random();
    idex_t e;
    logic  es, ec;
    logic [31:0] eb;
    for (int n = 0; n < 300; n++) begin
      pc_in = $urandom; inst_in = $urandom;
      inst_in[25:21] = 5'($urandom_range(0, 7));
      inst_in[20:16] = 5'($urandom_range(0, 7));
      if_valid = ($urandom_range(0, 3) != 0);
      wb_we = $urandom_range(0, 1); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      ex_fwd_data = $urandom; mem_fwd_data = $urandom;
      if ($urandom_range(0, 2) == 0) mem_fwd_data = ex_fwd_data;
      fwd_a_sel = 2'($urandom); fwd_b_sel = 2'($urandom); sign_ext = $urandom_range(0, 1);
      ex_mem_read = $urandom_range(0, 1); ex_rt = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 7) == 0);
      #1;
      es = m_stall();
      ec = (m_opnd(fwd_a_sel, inst_in[25:21]) == m_opnd(fwd_b_sel, inst_in[20:16]));
      eb = pc_in + m_imm() * 4;
      e  = m_idex();
      n_cmp++;
      if (stall !== es || cmp_eq !== ec || branch_target !== eb) begin
        n_fail++;
        $display("FAIL rnd_comb[%0d]: got %b/%b/%h want %b/%b/%h", n, stall, cmp_eq, branch_target, es, ec, eb);
      end
      tick();
      n_cmp++;
      if (obs_idex() !== e) begin
        n_fail++; $display("FAIL rnd_idex[%0d]: got %h want %h", n, obs_idex(), e);
      end
    end
    idle();
  endtask

  task automatic test_small();
    s_wb_we = 1; s_wb_addr = 3'd5; s_wb_data = 16'hBEEF;
    tick();
    s_wb_we = 0; s_inst = 32'h0; s_inst[25:21] = 5'b11101; s_inst[15:0] = 16'hFFFF;
    s_sx = 1; s_pc = 16'h0100; s_if_valid = 1;
    #1;
    n_cmp++;
    if (s_bt !== 16'h00FC) begin n_fail++; $display("FAIL small_target: got %h want 00fc", s_bt); end
    tick();
    n_cmp++;
    if (s_idex_rs !== 3'd5 || s_idex_rs_data !== 16'hBEEF || s_idex_imm !== 16'hFFFF || s_idex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL small_decode: got %0d/%h/%h/%b want 5/beef/ffff/1", s_idex_rs, s_idex_rs_data, s_idex_imm, s_idex_valid);
    end
    s_exr = 1; s_ex_rt = 3'd5;
    #1;
    n_cmp++;
    if (s_stall !== 1'b1) begin n_fail++; $display("FAIL small_stall: got %b want 1", s_stall); end
    s_flush = 1;
    #1;
    n_cmp++;
    if (s_stall !== 1'b0) begin n_fail++; $display("FAIL small_flush_stall: got %b want 0", s_stall); end
    tick();
    n_cmp++;
    if (s_idex_valid !== 1'b0 || s_idex_rs !== 3'd0 || s_idex_rs_data !== 16'd0) begin
      n_fail++; $display("FAIL small_bubble: got %b/%0d/%h want 0/0/0", s_idex_valid, s_idex_rs, s_idex_rs_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    s_pc = 0; s_inst = 0; s_if_valid = 0; s_wb_we = 0; s_wb_addr = 0; s_wb_data = 0;
    s_ex = 0; s_mem = 0; s_fa = 0; s_fb = 0; s_sx = 0; s_exr = 0; s_ex_rt = 0; s_flush = 0;
    test_reset();
    test_write_read();
    test_r0();
    test_bypass();
    test_load_use();
    test_branch();
    test_flush_stall();
    test_random();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
